// File: rtl/coded_frame_tx_pkg.sv
// Shared widths, frame lengths and state encoding for the coded-frame serializer.
// The macros carry the same values for code that still uses the global defines.
`ifndef CODED_FRAME_W
`define CODED_FRAME_W   384
`define RATE2_FRAME_LEN 256
`define RATE3_FRAME_LEN 384
`define TX_BIT_IDX_W    9
`endif

package coded_frame_tx_pkg;
  localparam int CODED_FRAME_W   = `CODED_FRAME_W;
  localparam int RATE2_FRAME_LEN = `RATE2_FRAME_LEN;
  localparam int RATE3_FRAME_LEN = `RATE3_FRAME_LEN;
  localparam int TX_BIT_IDX_W    = `TX_BIT_IDX_W;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  // Index of the final coded bit for a frame of the given rate (0: 1/2, 1: 1/3).
  function automatic logic [TX_BIT_IDX_W-1:0] last_idx(input logic rate);
    return rate ? TX_BIT_IDX_W'(RATE3_FRAME_LEN - 1) : TX_BIT_IDX_W'(RATE2_FRAME_LEN - 1);
  endfunction
endpackage

// File: rtl/coded_frame_tx_if.sv
// Frame-input and serial-output handshake bundle of the serializer.
// The encoder/channel side is the master; the serializer is the slave.
interface coded_frame_tx_if #(parameter int FRAME_W = 384);
  logic               i_code_rate;
  logic               i_frame_valid;
  logic [FRAME_W-1:0] i_frame;
  logic               o_frame_ready;
  logic               o_tx_bit;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_tx_sof;
  logic               o_tx_eof;

  modport master (output i_code_rate, i_frame_valid, i_frame, i_tx_ready,
                  input  o_frame_ready, o_tx_bit, o_tx_valid, o_tx_sof, o_tx_eof);
  modport slave  (input  i_code_rate, i_frame_valid, i_frame, i_tx_ready,
                  output o_frame_ready, o_tx_bit, o_tx_valid, o_tx_sof, o_tx_eof);
endinterface

// File: rtl/coded_frame_fifo.sv
// Synchronous DEPTH-entry FIFO of {rate, frame} entries; pushes while full and
// pops while empty are ignored, so a full FIFO never passes a push through.
module coded_frame_fifo #(
  parameter int W     = 385,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/coded_frame_tx.sv
// Coded-frame serializer: buffers frames with their rate and streams the valid
// bits LSB-first under valid/ready, back-to-back with no bubble between frames.
module coded_frame_tx
  import coded_frame_tx_pkg::*;
#(
  parameter int FRAME_W = CODED_FRAME_W,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  coded_frame_tx_if.slave  bus,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_frames_sent
);
  localparam int CW = $clog2(DEPTH + 1);

  tx_state_e               state, nxt;
  logic [FRAME_W-1:0]      frame_q;
  logic                    rate_q;
  logic [TX_BIT_IDX_W-1:0] idx;
  logic [FRAME_W:0]        fifo_dout;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    frame_ready, push, pop, hs, is_last;
  logic                    tx_valid, tx_sof, tx_eof;

  assign frame_ready = (fifo_count < CW'(DEPTH));
  assign push        = bus.i_frame_valid && !fifo_full;
  assign is_last     = (idx == last_idx(rate_q));
  assign hs          = tx_valid && bus.i_tx_ready;

  coded_frame_fifo #(.W(FRAME_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.i_code_rate, bus.i_frame}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      TX_IDLE:  if (!fifo_empty) nxt = TX_SHIFT;
      TX_SHIFT: if (hs && is_last && fifo_empty) nxt = TX_IDLE;
      default:  nxt = TX_IDLE;
    endcase
  end

  // The EOF handshake reloads from the FIFO in the same edge: zero-bubble frames.
  always_comb begin
    tx_valid = (state == TX_SHIFT);
    tx_sof   = tx_valid && (idx == '0);
    tx_eof   = tx_valid && is_last;
    pop      = !fifo_empty && ((state == TX_IDLE) || (hs && is_last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q       <= '0;
      rate_q        <= 1'b0;
      idx           <= '0;
      o_overflow    <= 1'b0;
      o_frames_sent <= '0;
    end else begin
      if (pop) begin
        {rate_q, frame_q} <= fifo_dout;
        idx               <= '0;
      end else if (hs) begin
        frame_q <= frame_q >> 1;
        idx     <= idx + 1'b1;
      end
      if (hs && is_last)                          o_frames_sent <= o_frames_sent + 1'b1;
      if (bus.i_frame_valid && !frame_ready)      o_overflow    <= 1'b1;
    end
  end

  // Gated so idle shows 0 rather than leftover upper bits of a rate-1/2 frame.
  assign bus.o_tx_bit      = tx_valid && frame_q[0];
  assign bus.o_tx_valid    = tx_valid;
  assign bus.o_tx_sof      = tx_sof;
  assign bus.o_tx_eof      = tx_eof;
  assign bus.o_frame_ready = frame_ready;
endmodule
